game_display_frame_animator: RTL and testbench

- Next-generation game-area frame block.
- Holds the live game-display rectangle and animates it toward a requested target rectangle, stepping once per frame tick.
- Produces per-pixel registered border, interior and flash-modulated border flags for the pixel mux.
- Sits between the game-phase controller (issues targets and flash requests) and the VGA colour mux.

---
 rtl/game_display_pkg.sv | 14 +
 rtl/game_display_frame_animator_if.sv | 27 ++
 rtl/game_display_edge_stepper.sv | 31 +++
 rtl/game_display_frame_animator.sv | 153 +++++++++++++++
 tb/tb_game_display_frame_animator.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/game_display_pkg.sv
// Shared types and constants for the game-display frame animator.
package game_display_pkg;

  localparam int COORD_W    = 10;
  localparam int SCREEN_MAX = 1023;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } state_t;

endpackage

// File: rtl/game_display_frame_animator_if.sv
// Target/flash request bus from the game-phase controller and live rectangle status back.
interface game_display_frame_animator_if;
  import game_display_pkg::*;

  logic   target_valid;
  coord_t target_x0;
  coord_t target_y0;
  coord_t target_x1;
  coord_t target_y1;
  logic   flash_req;
  coord_t cur_x0;
  coord_t cur_y0;
  coord_t cur_x1;
  coord_t cur_y1;
  logic   busy;
  logic   arrived;

  modport master (
    output target_valid, target_x0, target_y0, target_x1, target_y1, flash_req,
    input  cur_x0, cur_y0, cur_x1, cur_y1, busy, arrived
  );

  modport slave (
    input  target_valid, target_x0, target_y0, target_x1, target_y1, flash_req,
    output cur_x0, cur_y0, cur_x1, cur_y1, busy, arrived
  );
endinterface

// File: rtl/game_display_edge_stepper.sv
// Moves one rectangle edge toward its target by at most STEP pixels, never overshooting.
module game_display_edge_stepper
  import game_display_pkg::*;
#(
  parameter int STEP = 4
) (
  input  coord_t cur,
  input  coord_t tgt,
  input  logic   en,
  output coord_t next_val,
  output logic   at_target
);

  localparam coord_t STEP_W = (STEP > SCREEN_MAX) ? coord_t'(SCREEN_MAX) : coord_t'(STEP);

  logic [COORD_W:0] diff;
  logic [COORD_W:0] mag;
  coord_t           step_mag;

  always_comb begin
    diff     = {1'b0, tgt} - {1'b0, cur};
    mag      = diff[COORD_W] ? (~diff + 1'b1) : diff;
    step_mag = (mag > {1'b0, STEP_W}) ? STEP_W : mag[COORD_W-1:0];
    next_val = cur;
    if (en) begin
      next_val = diff[COORD_W] ? (cur - step_mag) : (cur + step_mag);
    end
    at_target = (next_val == tgt);
  end

endmodule

// File: rtl/game_display_frame_animator.sv
// Animates the live game rectangle toward a target once per frame tick and renders
// registered border/interior flags, with an optional blinking border flash.
module game_display_frame_animator
  import game_display_pkg::*;
#(
  parameter int BORDER       = 5,
  parameter int STEP         = 4,
  parameter int FLASH_FRAMES = 30,
  parameter int BLINK_PERIOD = 4,
  parameter int INIT_X0      = 160,
  parameter int INIT_Y0      = 120,
  parameter int INIT_X1      = 479,
  parameter int INIT_Y1      = 359
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   frame_tick,
  input  coord_t x,
  input  coord_t y,
  game_display_frame_animator_if.slave bus,
  output logic   render_border,
  output logic   render_inside
);

  localparam int FW = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);
  localparam int BW = (BLINK_PERIOD < 2) ? 1 : $clog2(BLINK_PERIOD);
  localparam logic [COORD_W:0] BORDER_W = (COORD_W+1)'(BORDER);
  localparam logic [COORD_W:0] MAX_W    = (COORD_W+1)'(SCREEN_MAX);
  // Edge order in the packed arrays: [0]=x0, [1]=y0, [2]=x1, [3]=y1.
  localparam coord_t [3:0] INIT_RECT = {coord_t'(INIT_Y1), coord_t'(INIT_X1),
                                        coord_t'(INIT_Y0), coord_t'(INIT_X0)};

  coord_t [3:0] cur_reg;
  coord_t [3:0] tgt_reg;
  coord_t [3:0] next_val;
  coord_t [3:0] req;
  logic   [3:0] at_tgt;

  state_t  state_reg, state_next;
  logic    arrived_reg, arrived_next;
  logic    target_ok, step_en;
  logic [FW-1:0] flash_cnt_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          phase_reg;

  assign req       = {bus.target_y1, bus.target_x1, bus.target_y0, bus.target_x0};
  assign target_ok = bus.target_valid && (bus.target_x0 <= bus.target_x1)
                                      && (bus.target_y0 <= bus.target_y1);
  assign step_en   = (state_reg == MOVING) && frame_tick;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_edge
      game_display_edge_stepper #(.STEP(STEP)) u_stepper (
        .cur       (cur_reg[gi]),
        .tgt       (tgt_reg[gi]),
        .en        (step_en),
        .next_val  (next_val[gi]),
        .at_target (at_tgt[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    arrived_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (target_ok && (req != cur_reg)) state_next = MOVING;
      end
      MOVING: begin
        // A fresh target loaded on the arrival tick keeps the move going.
        if (step_en && (&at_tgt) && !(target_ok && (req != next_val))) begin
          state_next   = IDLE;
          arrived_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      arrived_reg <= 1'b0;
      cur_reg     <= INIT_RECT;
      tgt_reg     <= INIT_RECT;
    end else begin
      state_reg   <= state_next;
      arrived_reg <= arrived_next;
      if (step_en) cur_reg <= next_val;
      if (target_ok) tgt_reg <= req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_cnt_reg <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else if (bus.flash_req) begin
      flash_cnt_reg <= FW'(FLASH_FRAMES);
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else if (frame_tick && (flash_cnt_reg != '0)) begin
      flash_cnt_reg <= flash_cnt_reg - 1'b1;
      if (flash_cnt_reg == FW'(1)) begin
        phase_reg     <= 1'b1;
        blink_cnt_reg <= '0;
      end else if (blink_cnt_reg == BW'(BLINK_PERIOD - 1)) begin
        phase_reg     <= ~phase_reg;
        blink_cnt_reg <= '0;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  logic [COORD_W:0] bx0, by0, bx1, by1, sx1, sy1;
  logic inside_c, outer_c;

  // Outer box is computed in 11 bits and clamped so it never wraps across the screen.
  always_comb begin
    bx0 = ({1'b0, cur_reg[0]} >= BORDER_W) ? ({1'b0, cur_reg[0]} - BORDER_W) : '0;
    by0 = ({1'b0, cur_reg[1]} >= BORDER_W) ? ({1'b0, cur_reg[1]} - BORDER_W) : '0;
    sx1 = {1'b0, cur_reg[2]} + BORDER_W;
    sy1 = {1'b0, cur_reg[3]} + BORDER_W;
    bx1 = (sx1 > MAX_W) ? MAX_W : sx1;
    by1 = (sy1 > MAX_W) ? MAX_W : sy1;
    inside_c = (x >= cur_reg[0]) && (x <= cur_reg[2]) &&
               (y >= cur_reg[1]) && (y <= cur_reg[3]);
    outer_c  = ({1'b0, x} >= bx0) && ({1'b0, x} <= bx1) &&
               ({1'b0, y} >= by0) && ({1'b0, y} <= by1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      render_border <= 1'b0;
      render_inside <= 1'b0;
    end else begin
      render_border <= outer_c && !inside_c && phase_reg;
      render_inside <= inside_c;
    end
  end

  assign bus.cur_x0  = cur_reg[0];
  assign bus.cur_y0  = cur_reg[1];
  assign bus.cur_x1  = cur_reg[2];
  assign bus.cur_y1  = cur_reg[3];
  assign bus.busy    = (state_reg == MOVING);
  assign bus.arrived = arrived_reg;

endmodule

// File: tb/tb_game_display_frame_animator.sv
// Directed bench for the frame animator: moves, clamped border, flash blink and reset mid-move.
module tb_game_display_frame_animator;
  import game_display_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   frame_tick = 1'b0;
  coord_t x = '0;
  coord_t y = '0;
  logic   render_border, render_inside;
  int     n_checks = 0;
  int     n_fail = 0;

  game_display_frame_animator_if bus_if ();

  game_display_frame_animator #(
    .BORDER(5), .STEP(4), .FLASH_FRAMES(8), .BLINK_PERIOD(2),
    .INIT_X0(160), .INIT_Y0(120), .INIT_X1(479), .INIT_Y1(359)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .x             (x),
    .y             (y),
    .bus           (bus_if.slave),
    .render_border (render_border),
    .render_inside (render_inside)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic send_target(input int x0, input int y0, input int x1, input int y1);
    @(negedge clk);
    bus_if.target_valid = 1'b1;
    bus_if.target_x0 = coord_t'(x0);
    bus_if.target_y0 = coord_t'(y0);
    bus_if.target_x1 = coord_t'(x1);
    bus_if.target_y1 = coord_t'(y1);
    @(negedge clk) bus_if.target_valid = 1'b0;
  endtask

  task automatic flash();
    @(negedge clk) bus_if.flash_req = 1'b1;
    @(negedge clk) bus_if.flash_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic pix(input string tag, input int px, input int py, input int eb, input int ei);
    @(negedge clk);
    x = coord_t'(px);
    y = coord_t'(py);
    @(negedge clk);
    check_value({tag, " border"}, int'(render_border), eb);
    check_value({tag, " inside"}, int'(render_inside), ei);
  endtask

  int pattern [11] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1};

  initial begin
    bus_if.target_valid = 1'b0;
    bus_if.target_x0 = '0;
    bus_if.target_y0 = '0;
    bus_if.target_x1 = '0;
    bus_if.target_y1 = '0;
    bus_if.flash_req = 1'b0;
    repeat (3) @(negedge clk);
    check_value("reset x0", int'(bus_if.cur_x0), 160);
    check_value("reset y0", int'(bus_if.cur_y0), 120);
    check_value("reset x1", int'(bus_if.cur_x1), 479);
    check_value("reset y1", int'(bus_if.cur_y1), 359);
    check_value("reset busy", int'(bus_if.busy), 0);
    check_value("reset arrived", int'(bus_if.arrived), 0);
    check_value("reset border", int'(render_border), 0);
    check_value("reset inside", int'(render_inside), 0);
    reset = 1'b0;

    // 40-pixel move at STEP 4 takes ten ticks
    send_target(200, 120, 479, 359);
    check_value("mv1 busy start", int'(bus_if.busy), 1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_value($sformatf("mv1 t%0d x0", i), int'(bus_if.cur_x0), 160 + 4 * i);
      check_value($sformatf("mv1 t%0d busy", i), int'(bus_if.busy), (i < 10) ? 1 : 0);
      check_value($sformatf("mv1 t%0d arrived", i), int'(bus_if.arrived), (i == 10) ? 1 : 0);
    end
    @(negedge clk);
    check_value("mv1 arrived drop", int'(bus_if.arrived), 0);

    // delta 6: 4 then 2
    send_target(206, 120, 479, 359);
    tick();
    check_value("mv2 t1 x0", int'(bus_if.cur_x0), 204);
    check_value("mv2 t1 arrived", int'(bus_if.arrived), 0);
    tick();
    check_value("mv2 t2 x0", int'(bus_if.cur_x0), 206);
    check_value("mv2 t2 arrived", int'(bus_if.arrived), 1);
    check_value("mv2 t2 busy", int'(bus_if.busy), 0);

    // inverted target must be ignored
    send_target(300, 120, 100, 359);
    check_value("bad busy", int'(bus_if.busy), 0);
    tick();
    check_value("bad x0", int'(bus_if.cur_x0), 206);
    check_value("bad x1", int'(bus_if.cur_x1), 479);
    check_value("bad busy tick", int'(bus_if.busy), 0);
    check_value("bad arrived", int'(bus_if.arrived), 0);

    // same rectangle again: no move, no arrival
    send_target(206, 120, 479, 359);
    check_value("same busy", int'(bus_if.busy), 0);
    check_value("same arrived", int'(bus_if.arrived), 0);

    // move left edge to 2 (204 px = 51 ticks)
    send_target(2, 120, 479, 359);
    for (int i = 1; i <= 51; i++) tick();
    check_value("mv3 x0", int'(bus_if.cur_x0), 2);
    check_value("mv3 arrived", int'(bus_if.arrived), 1);
    pix("clip x0", 0, 200, 1, 0);
    pix("wrap alias", 1020, 200, 0, 0);
    pix("interior", 100, 200, 0, 1);
    pix("edge x1", 479, 200, 0, 1);
    pix("ring x1", 484, 200, 1, 0);
    pix("past ring", 485, 200, 0, 0);
    pix("ring top", 1, 115, 1, 0);
    pix("above ring", 1, 114, 0, 0);

    // flash on a border pixel
    pix("pre flash", 100, 117, 1, 0);
    flash();
    check_value("fl1 k0", int'(render_border), pattern[0]);
    for (int k = 1; k <= 10; k++) begin
      tick();
      @(negedge clk);
      check_value($sformatf("fl1 k%0d", k), int'(render_border), pattern[k]);
    end
    flash();
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge clk);
      check_value($sformatf("fl2 k%0d", k), int'(render_border), pattern[k]);
    end
    flash();
    check_value("fl2 restart", int'(render_border), 1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      @(negedge clk);
      check_value($sformatf("fl2r k%0d", k), int'(render_border), pattern[k]);
    end

    // retarget on a tick edge: step still heads to the old target
    send_target(42, 120, 479, 359);
    tick();
    tick();
    check_value("rt pre x0", int'(bus_if.cur_x0), 10);
    @(negedge clk);
    bus_if.target_valid = 1'b1;
    bus_if.target_x0 = 10'd2;
    frame_tick = 1'b1;
    @(negedge clk);
    bus_if.target_valid = 1'b0;
    frame_tick = 1'b0;
    check_value("rt coincident x0", int'(bus_if.cur_x0), 14);
    check_value("rt busy", int'(bus_if.busy), 1);
    tick();
    check_value("rt new dir x0", int'(bus_if.cur_x0), 10);

    // asynchronous reset mid-move
    @(negedge clk) reset = 1'b1;
    #1;
    check_value("rst x0", int'(bus_if.cur_x0), 160);
    check_value("rst x1", int'(bus_if.cur_x1), 479);
    check_value("rst busy", int'(bus_if.busy), 0);
    check_value("rst arrived", int'(bus_if.arrived), 0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_value($sformatf("post rst %0d arrived", i), int'(bus_if.arrived), 0);
      check_value($sformatf("post rst %0d x0", i), int'(bus_if.cur_x0), 160);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
